// File: rtl/lcd_fmt_pkg.sv
// Shared state type, character constants and ASCII helpers for the LCD debug formatter.
package lcd_fmt_pkg;

    typedef enum logic [1:0] {IDLE, SNAP, EMIT, COMMIT} fmt_state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_QMARK = 8'h3F;
    localparam logic [7:0] CHAR_COLON = 8'h3A;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        return 8'h37 + {4'h0, nib};
    endfunction

    // Channels 0..25 are labelled A..Z, later ones a..z.
    function automatic logic [7:0] ch_label(input int ch);
        logic [7:0] c8;
        c8 = ch[7:0];
        if (ch < 26) return 8'h41 + c8;
        return 8'h61 + (c8 - 8'd26);
    endfunction

endpackage

// File: rtl/lcd_page_ctrl.sv
// Page register with wrap-around and page_changed pulse.
// Optional auto-paging hold counter is built only when LCD_FMT_AUTOPAGE_EN is defined.
module lcd_page_ctrl
    import lcd_fmt_pkg::*;
#(
    parameter int NPAGE     = 4,
    parameter int PW        = 2,
    parameter int PAGE_HOLD = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          page_next,
    input  logic          page_prev,
    output logic [PW-1:0] page,
    output logic          page_changed
);

    localparam logic [PW-1:0] LAST_PAGE = PW'(NPAGE - 1);

    logic step_fwd;
    logic step_back;
    logic manual;
    logic advance;

    // Simultaneous next/prev pulses cancel each other.
    assign step_fwd  = page_next & ~page_prev;
    assign step_back = page_prev & ~page_next;
    assign manual    = step_fwd | step_back;

`ifdef LCD_FMT_AUTOPAGE_EN
    localparam int            HW        = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(PAGE_HOLD - 1);

    logic [HW-1:0] hold_cnt;
    logic          hold_tc;

    assign hold_tc = (hold_cnt == '0);

    // Manual page moves restart the hold period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= HOLD_LOAD;
        end else if (manual || hold_tc) begin
            hold_cnt <= HOLD_LOAD;
        end else begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    assign advance = step_fwd | (hold_tc & ~manual);
`else
    localparam int hold_unused = PAGE_HOLD;

    assign advance = step_fwd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page <= '0;
        end else if (advance) begin
            page <= (page == LAST_PAGE) ? '0 : page + PW'(1);
        end else if (step_back) begin
            page <= (page == '0) ? LAST_PAGE : page - PW'(1);
        end
    end

    assign page_changed = advance | step_back;

endmodule

// File: rtl/lcd_debug_formatter.sv
// Paged hex formatter for the 2x16 LCD debug path; builds a frame in a shadow buffer
// and commits both rows at once. LCD_FMT_AUTOPAGE_EN enables timed auto-paging.
//
// state  | meaning
// IDLE   | waiting for a pending frame request
// SNAP   | latch the page and its two channel words
// EMIT   | render one character per cycle into the shadow buffer (idx 0..31)
// COMMIT | copy shadow buffer to row_A/row_B in one cycle
module lcd_debug_formatter
    import lcd_fmt_pkg::*;
#(
    parameter  int NUM_CH      = 8,
    parameter  int CH_WIDTH    = 16,
    parameter  int REFRESH_CYC = 2_500_000,
    parameter  int PAGE_HOLD   = 50_000_000,
    localparam int NPAGE       = (NUM_CH + 1) / 2,
    localparam int PW          = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       page_next,
    input  logic                       page_prev,
    input  logic                       refresh_req,
    output logic [127:0]               row_A,
    output logic [127:0]               row_B,
    output logic [PW-1:0]              page,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int NDIG  = CH_WIDTH / 4;
    localparam int RW    = $clog2(REFRESH_CYC);
    localparam int EXT_W = 2 * NPAGE * CH_WIDTH;

    fmt_state_t            state_q;
    fmt_state_t            state_d;
    logic [RW-1:0]         refresh_cnt;
    logic                  refresh_hit;
    logic                  page_changed;
    logic                  trigger;
    logic                  pending;
    logic [EXT_W-1:0]      ch_ext;
    logic [CH_WIDTH-1:0]   snap_a;
    logic [CH_WIDTH-1:0]   snap_b;
    logic [PW-1:0]         snap_page;
    logic                  snap_b_valid;
    logic [4:0]            idx;
    logic [255:0]          shadow;
    logic [7:0]            emit_char;
    logic [CH_WIDTH-1:0]   line_word;
    int                    pos;
    int                    line_ch;

    lcd_page_ctrl #(
        .NPAGE     (NPAGE),
        .PW        (PW),
        .PAGE_HOLD (PAGE_HOLD)
    ) u_page_ctrl (
        .clk          (clk),
        .reset        (reset),
        .page_next    (page_next),
        .page_prev    (page_prev),
        .page         (page),
        .page_changed (page_changed)
    );

    // Zero-extended so the missing odd channel on the last page never indexes out of range.
    assign ch_ext      = EXT_W'(ch_data);
    assign refresh_hit = (refresh_cnt == RW'(REFRESH_CYC - 1));
    assign trigger     = refresh_hit | refresh_req | page_changed;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending) state_d = SNAP;
            SNAP:    state_d = EMIT;
            EMIT:    if (idx == 5'd31) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        emit_char = CHAR_SPACE;
        line_word = idx[4] ? snap_b : snap_a;
        pos       = int'(idx[3:0]);
        line_ch   = 2 * int'(snap_page) + int'(idx[4]);
        if (idx[4] && !snap_b_valid) begin
            emit_char = CHAR_SPACE;
        end else if (pos == 0) begin
            emit_char = ch_label(line_ch);
        end else if (pos == 1) begin
            emit_char = CHAR_COLON;
        end else if (pos < NDIG + 2) begin
            emit_char = nib2ascii(line_word[4*(NDIG+1-pos) +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt  <= '0;
            pending      <= 1'b1;
            snap_a       <= '0;
            snap_b       <= '0;
            snap_page    <= '0;
            snap_b_valid <= 1'b0;
            idx          <= '0;
            shadow       <= {32{CHAR_SPACE}};
            row_A        <= {16{CHAR_QMARK}};
            row_B        <= {16{CHAR_QMARK}};
            frame_done   <= 1'b0;
        end else begin
            refresh_cnt <= refresh_hit ? '0 : refresh_cnt + RW'(1);

            // Triggers during a build only mark a follow-up frame.
            if (trigger) begin
                pending <= 1'b1;
            end else if (state_q == IDLE) begin
                pending <= 1'b0;
            end

            if (state_q == SNAP) begin
                snap_a       <= ch_ext[2*int'(page)*CH_WIDTH +: CH_WIDTH];
                snap_b       <= ch_ext[(2*int'(page)+1)*CH_WIDTH +: CH_WIDTH];
                snap_page    <= page;
                snap_b_valid <= (2 * int'(page) + 1) < NUM_CH;
            end

            if (state_q == EMIT) begin
                shadow[8*(31-int'(idx)) +: 8] <= emit_char;
                idx                           <= idx + 5'd1;
            end else begin
                idx <= '0;
            end

            if (state_q == COMMIT) begin
                row_A <= shadow[255:128];
                row_B <= shadow[127:0];
            end

            frame_done <= (state_q == COMMIT);
        end
    end

endmodule
